// File: rtl/x_dl_pkg.sv
// x_dl_pkg -- shared definitions for the delay-line sampler.
//   state_e   : sampler FSM states (IDLE, ACC, DONE)
//   cnt_width : bits needed to hold a tap count 0..width
//   sel_width : bits needed to select one of chans channels (minimum 1)
package x_dl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic int sel_width(input int chans);
      return (chans > 1) ? $clog2(chans) : 1;
   endfunction

endpackage

// File: rtl/x_dl_therm2cnt.sv
// x_dl_therm2cnt -- combinational thermometer-to-count converter.
// The count is the index of the first 0 bit scanning upward from bit 0.
// All ones gives p_width. Bubbles above the first 0 are ignored.
//   i_therm : raw tap samples of one delay-line channel
//   o_cnt   : tap count, 0..p_width
module x_dl_therm2cnt
   import x_dl_pkg::*;
#(
   parameter  int p_width = 32,
   localparam int CW      = cnt_width(p_width)
) (
   input  logic [p_width-1:0] i_therm,
   output logic [CW-1:0]      o_cnt
);

   // Downward scan: the lowest zero index is written last, so it wins.
   always_comb begin
      o_cnt = CW'(p_width);
      for (int i = p_width - 1; i >= 0; i--) begin
         o_cnt = i_therm[i] ? o_cnt : CW'(i);
      end
   end

endmodule

// File: rtl/x_dl_sampler.sv
// x_dl_sampler -- delay-line sampler. It averages 2^p_log_avg tap counts
// from one selected channel and tracks the minimum and maximum count in the window.
//   i_clk, i_rst_n      : clock and synchronous active-low reset
//   i_dl, i_dl_valid    : raw tap samples for all channels, with a qualifier
//   i_start, i_chan,
//   i_cont, i_stop      : measurement control (start, channel, continuous mode, abort)
//   o_valid, i_accept   : result handshake
//   o_avg, o_min,
//   o_max, o_chan       : registered result, held stable while o_valid is high
//   o_busy              : high whenever the FSM is not in IDLE
//   o_drop              : sticky flag, set when a sample arrives while a result is pending
module x_dl_sampler
   import x_dl_pkg::*;
#(
   parameter  int p_width   = 32,
   parameter  int p_chans   = 4,
   parameter  int p_log_avg = 4,
   localparam int CW        = cnt_width(p_width),
   localparam int CHW       = sel_width(p_chans)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [p_chans*p_width-1:0] i_dl,
   input  logic                       i_dl_valid,
   input  logic                       i_start,
   input  logic [CHW-1:0]             i_chan,
   input  logic                       i_cont,
   input  logic                       i_stop,
   output logic                       o_valid,
   input  logic                       i_accept,
   output logic [CW-1:0]              o_avg,
   output logic [CW-1:0]              o_min,
   output logic [CW-1:0]              o_max,
   output logic [CHW-1:0]             o_chan,
   output logic                       o_busy,
   output logic                       o_drop
);

   localparam int SW   = CW + p_log_avg;
   localparam int CNTW = (p_log_avg > 0) ? p_log_avg : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << p_log_avg) - 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(p_width);
   localparam logic [CHW:0]    CHAN_TOP = (CHW + 1)'(p_chans - 1);

   state_e          state_q, state_d;
   logic [CHW-1:0]  chan_q, chan_d;
   logic            cont_q, cont_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]   min_q, min_d;
   logic [CW-1:0]   max_q, max_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            drop_q, drop_d;
   logic [CW-1:0]   avg_q, avg_d;
   logic [CW-1:0]   rmin_q, rmin_d;
   logic [CW-1:0]   rmax_q, rmax_d;
   logic [CHW-1:0]  rchan_q, rchan_d;

   logic [p_width-1:0] dl_sel_s;
   logic [CW-1:0]      tap_cnt_s;
   logic [SW-1:0]      sum_nxt_s;
   logic [CW-1:0]      min_nxt_s;
   logic [CW-1:0]      max_nxt_s;
   logic               xfer_s;

   // Select the measured channel's tap word.
   always_comb begin
      dl_sel_s = i_dl[p_width-1:0];
      for (int c = 0; c < p_chans; c++) begin
         dl_sel_s = (chan_q == CHW'(c)) ? i_dl[c*p_width +: p_width] : dl_sel_s;
      end
   end

   x_dl_therm2cnt #(
      .p_width (p_width)
   ) u_therm2cnt (
      .i_therm (dl_sel_s),
      .o_cnt   (tap_cnt_s)
   );

   // Running statistics including the current sample, used on every accepted sample.
   always_comb begin
      sum_nxt_s = sum_q + SW'(tap_cnt_s);
      min_nxt_s = (tap_cnt_s < min_q) ? tap_cnt_s : min_q;
      max_nxt_s = (tap_cnt_s > max_q) ? tap_cnt_s : max_q;
      xfer_s    = valid_q & i_accept;
   end

   // Next-state and next-output computation for the sampler FSM.
   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      cont_d  = cont_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      min_d   = min_q;
      max_d   = max_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      drop_d  = drop_q;
      avg_d   = avg_q;
      rmin_d  = rmin_q;
      rmax_d  = rmax_q;
      rchan_d = rchan_q;
      case (state_q)
         ST_IDLE: begin
            // An abort in the same cycle overrides a start request.
            if (i_start && !i_stop) begin
               state_d = ST_ACC;
               chan_d  = ({1'b0, i_chan} > CHAN_TOP) ? CHAN_TOP[CHW-1:0] : i_chan;
               cont_d  = i_cont;
               sum_d   = '0;
               cnt_d   = '0;
               min_d   = CNT_FULL;
               max_d   = '0;
               drop_d  = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (i_stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (i_dl_valid) begin
               sum_d = sum_nxt_s;
               min_d = min_nxt_s;
               max_d = max_nxt_s;
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
                  avg_d   = CW'(sum_nxt_s >> p_log_avg);
                  rmin_d  = min_nxt_s;
                  rmax_d  = max_nxt_s;
                  rchan_d = chan_q;
               end else begin
                  state_d = ST_ACC;
               end
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_DONE: begin
            // Samples are discarded while a result is pending; the loss is flagged.
            drop_d = drop_q | i_dl_valid;
            if (i_stop || (xfer_s && !cont_q)) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (xfer_s) begin
               state_d = ST_ACC;
               valid_d = 1'b0;
               sum_d   = '0;
               cnt_d   = '0;
               min_d   = CNT_FULL;
               max_d   = '0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers, with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         chan_q  <= '0;
         cont_q  <= 1'b0;
         sum_q   <= '0;
         cnt_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
         avg_q   <= '0;
         rmin_q  <= '0;
         rmax_q  <= '0;
         rchan_q <= '0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         cont_q  <= cont_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         min_q   <= min_d;
         max_q   <= max_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
         avg_q   <= avg_d;
         rmin_q  <= rmin_d;
         rmax_q  <= rmax_d;
         rchan_q <= rchan_d;
      end
   end

   assign o_valid = valid_q;
   assign o_avg   = avg_q;
   assign o_min   = rmin_q;
   assign o_max   = rmax_q;
   assign o_chan  = rchan_q;
   assign o_busy  = busy_q;
   assign o_drop  = drop_q;

endmodule

// File: tb/tb_x_dl_sampler.sv
// Testbench for x_dl_sampler with p_width=32, p_chans=4 and p_log_avg=2.
// A table of single-shot windows is applied in a loop. Hand-written
// sequences then cover continuous mode, stop, and reset.
module tb_x_dl_sampler;

   localparam int W   = 32;
   localparam int NC  = 4;
   localparam int LA  = 2;
   localparam int CW  = 6;
   localparam int CHW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NC*W-1:0] dl;
   logic            dl_valid;
   logic            start;
   logic [CHW-1:0]  chan;
   logic            cont;
   logic            stop;
   logic            valid;
   logic            accept;
   logic [CW-1:0]   avg;
   logic [CW-1:0]   vmin;
   logic [CW-1:0]   vmax;
   logic [CHW-1:0]  ochan;
   logic            busy;
   logic            drop;

   int checks = 0;
   int errors = 0;

   x_dl_sampler #(
      .p_width   (W),
      .p_chans   (NC),
      .p_log_avg (LA)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_dl       (dl),
      .i_dl_valid (dl_valid),
      .i_start    (start),
      .i_chan     (chan),
      .i_cont     (cont),
      .i_stop     (stop),
      .o_valid    (valid),
      .i_accept   (accept),
      .o_avg      (avg),
      .o_min      (vmin),
      .o_max      (vmax),
      .o_chan     (ochan),
      .o_busy     (busy),
      .o_drop     (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              ch;
      logic [3:0][W-1:0] raw;
      int              gap;
      int              e_avg;
      int              e_min;
      int              e_max;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] therm(input int n);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_sample(input int ch, input logic [W-1:0] word);
      for (int c = 0; c < NC; c++) begin
         dl[c*W +: W] = (c == ch) ? word : W'($urandom());
      end
      dl_valid = 1'b1;
      tick();
      dl_valid = 1'b0;
   endtask

   task automatic do_start(input int ch, input logic md);
      chan  = CHW'(ch);
      cont  = md;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_result(input string tag, input int a, input int mn, input int mx, input int c);
      chk({tag, "_valid"}, 64'(valid), 64'd1);
      chk({tag, "_avg"},   64'(avg),   64'(a));
      chk({tag, "_min"},   64'(vmin),  64'(mn));
      chk({tag, "_max"},   64'(vmax),  64'(mx));
      chk({tag, "_chan"},  64'(ochan), 64'(c));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(valid), 64'd0);
      chk({tag, "_busy"},  64'(busy),  64'd0);
      chk({tag, "_drop"},  64'(drop),  64'd0);
      chk({tag, "_avg"},   64'(avg),   64'd0);
      chk({tag, "_min"},   64'(vmin),  64'd0);
      chk({tag, "_max"},   64'(vmax),  64'd0);
      chk({tag, "_chan"},  64'(ochan), 64'd0);
   endtask

   initial begin
      logic seen_valid;

      // Window table: expected values are worked out by hand from the tap words.
      vecs[0].ch = 1; vecs[0].gap = 0;
      vecs[0].raw[0] = therm(10); vecs[0].raw[1] = therm(12);
      vecs[0].raw[2] = therm(14); vecs[0].raw[3] = therm(16);
      vecs[0].e_avg = 13; vecs[0].e_min = 10; vecs[0].e_max = 16;

      vecs[1].ch = 0; vecs[1].gap = 0;
      vecs[1].raw[0] = 32'h0000_FF7F; vecs[1].raw[1] = 32'hFFFF_FFFF;
      vecs[1].raw[2] = 32'h0000_0000; vecs[1].raw[3] = 32'h0000_FF7F;
      vecs[1].e_avg = 11; vecs[1].e_min = 0; vecs[1].e_max = 32;

      vecs[2].ch = 3; vecs[2].gap = 2;
      vecs[2].raw[0] = 32'hF0F0_F0F1; vecs[2].raw[1] = 32'h8000_0003;
      vecs[2].raw[2] = 32'hFFFF_FFFB; vecs[2].raw[3] = 32'h0000_0007;
      vecs[2].e_avg = 2; vecs[2].e_min = 1; vecs[2].e_max = 3;

      vecs[3].ch = 2; vecs[3].gap = 1;
      vecs[3].raw[0] = 32'h7FFF_FFFF; vecs[3].raw[1] = 32'h7FFF_FFFF;
      vecs[3].raw[2] = 32'h7FFF_FFFF; vecs[3].raw[3] = 32'h3FFF_FFFF;
      vecs[3].e_avg = 30; vecs[3].e_min = 30; vecs[3].e_max = 31;

      rst_n    = 1'b0;
      dl       = '0;
      dl_valid = 1'b0;
      start    = 1'b0;
      chan     = '0;
      cont     = 1'b0;
      stop     = 1'b0;
      accept   = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Table-driven single-shot windows.
      for (int v = 0; v < 4; v++) begin
         do_start(vecs[v].ch, 1'b0);
         chk($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
         for (int s = 0; s < 4; s++) begin
            if (s == 3) chk($sformatf("v%0d_early_valid", v), 64'(valid), 64'd0);
            put_sample(vecs[v].ch, vecs[v].raw[s]);
            if (s < 3) begin
               for (int g = 0; g < vecs[v].gap; g++) tick();
            end
         end
         chk_result($sformatf("v%0d", v), vecs[v].e_avg, vecs[v].e_min, vecs[v].e_max, vecs[v].ch);
         tick();
         chk($sformatf("v%0d_hold_valid", v), 64'(valid), 64'd1);
         chk($sformatf("v%0d_hold_avg", v), 64'(avg), 64'(vecs[v].e_avg));
         accept = 1'b1;
         tick();
         accept = 1'b0;
         chk($sformatf("v%0d_post_valid", v), 64'(valid), 64'd0);
         chk($sformatf("v%0d_post_busy", v), 64'(busy), 64'd0);
      end

      // Continuous mode: result held under back-pressure, samples dropped.
      do_start(1, 1'b1);
      for (int s = 0; s < 4; s++) put_sample(1, therm(4));
      chk_result("cont1", 4, 4, 4, 1);
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < NC; c++) dl[c*W +: W] = therm(20 + k);
         dl_valid = 1'b1;
         tick();
         chk_result($sformatf("stall%0d", k), 4, 4, 4, 1);
         chk($sformatf("stall%0d_drop", k), 64'(drop), 64'd1);
      end
      dl_valid = 1'b0;
      accept   = 1'b1;
      tick();
      accept = 1'b0;
      chk("cont_rearm_valid", 64'(valid), 64'd0);
      chk("cont_rearm_busy", 64'(busy), 64'd1);
      chk("cont_rearm_drop", 64'(drop), 64'd1);
      put_sample(1, therm(8));
      put_sample(1, therm(9));
      put_sample(1, therm(10));
      put_sample(1, therm(11));
      chk_result("cont2", 9, 8, 11, 1);
      // Stop and accept together: one transfer, then IDLE.
      stop   = 1'b1;
      accept = 1'b1;
      tick();
      stop   = 1'b0;
      accept = 1'b0;
      chk("stopxfer_valid", 64'(valid), 64'd0);
      chk("stopxfer_busy", 64'(busy), 64'd0);
      tick();
      chk("stopxfer_idle", 64'(busy), 64'd0);
      do_start(0, 1'b0);
      chk("drop_clear", 64'(drop), 64'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_acc0_busy", 64'(busy), 64'd0);

      // Stop after two samples; no result may appear.
      do_start(2, 1'b0);
      put_sample(2, therm(20));
      put_sample(2, therm(20));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", 64'(busy), 64'd0);
      seen_valid = valid;
      for (int k = 0; k < 6; k++) begin
         put_sample(2, therm(20));
         seen_valid = seen_valid | valid;
      end
      chk("stop_no_valid", 64'(seen_valid), 64'd0);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_idle", 64'(busy), 64'd0);
      do_start(2, 1'b0);
      put_sample(2, therm(1));
      chan  = 2'd0;
      start = 1'b1;
      put_sample(2, therm(2));
      start = 1'b0;
      put_sample(2, therm(3));
      put_sample(2, therm(4));
      chk_result("restart", 2, 1, 4, 2);

      // Reset during ACC and during DONE.
      accept = 1'b1;
      tick();
      accept = 1'b0;
      do_start(3, 1'b0);
      put_sample(3, therm(5));
      put_sample(3, therm(5));
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("rst_acc");
      rst_n = 1'b1;
      tick();
      do_start(3, 1'b0);
      for (int s = 0; s < 4; s++) put_sample(3, therm(5));
      chk_result("pre_rst", 5, 5, 5, 3);
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("rst_done");
      rst_n = 1'b1;
      tick();
      chk("after_rst_valid", 64'(valid), 64'd0);
      chk("after_rst_busy", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/x_dl_sampler.md
X_DL_SAMPLER -- requirements
Module: x_dl_sampler

Interface
REQ-001 SHALL have parameter p_width, default 32, meaning taps per delay-line channel (thermometer code width, 2..64).
REQ-002 SHALL have parameter p_chans, default 4, meaning number of delay-line channels (1..8).
REQ-003 SHALL have parameter p_log_avg, default 4, meaning log2 of samples averaged per result (0..8).
REQ-004 SHALL derive CW = $clog2(p_width+1) and CHW = max(1,$clog2(p_chans)).
REQ-005 Port: i_clk  input  1  the single clock.
REQ-006 Port: i_rst_n  input  1  reset; synchronous, active-low.
REQ-007 Port: i_dl  input  p_chans*p_width  raw tap samples; channel c occupies bits [c*p_width +: p_width].
REQ-008 Port: i_dl_valid  input  1  i_dl holds a new sample set this cycle.
REQ-009 Port: i_start  input  1  begin measurement (single-cycle pulse).
REQ-010 Port: i_chan  input  CHW  channel to measure, sampled with i_start.
REQ-011 Port: i_cont  input  1  mode, sampled with i_start: 0 single-shot, 1 continuous.
REQ-012 Port: i_stop  input  1  abort measurement, return to idle.
REQ-013 Port: o_valid  output  1  result available.
REQ-014 Port: i_accept  input  1  consumer takes result; transfer when o_valid && i_accept.
REQ-015 Port: o_avg  output  CW  averaged tap count.
REQ-016 Port: o_min / o_max  output  CW each  minimum / maximum count within window.
REQ-017 Port: o_chan  output  CHW  channel of the current result.
REQ-018 Port: o_busy  output  1  high in any state other than IDLE.
REQ-019 Port: o_drop  output  1  sticky: a valid sample arrived while in DONE.

Function
REQ-020 Per-sample count SHALL equal the index of the first 0 bit of the selected channel, scanning from bit 0; all ones -> p_width; bit 0 low -> 0 (bubbles above the first 0 ignored).
REQ-021 FSM SHALL have states IDLE, ACC, DONE.
REQ-022 IDLE: i_start -> ACC next cycle; capture i_chan, i_cont; clear accumulator, sample counter, min=p_width, max=0.
REQ-023 i_chan >= p_chans at start SHALL be clamped to p_chans-1.
REQ-024 ACC: each i_dl_valid cycle SHALL add count to a (CW+p_log_avg)-bit sum and update min/max; the 2^p_log_avg-th sample -> DONE next cycle.
REQ-025 o_avg SHALL equal sum >> p_log_avg (truncating); o_avg/o_min/o_max/o_chan registered, stable throughout DONE.
REQ-026 Latency: o_valid SHALL rise the cycle after the last sample of the window is taken.
REQ-027 DONE: o_valid=1; on transfer, single-shot -> IDLE, continuous -> ACC with accumulator/min/max/counter cleared in the same edge.
REQ-028 i_dl_valid in DONE SHALL be discarded and set o_drop; o_drop clears only on i_start accepted in IDLE or reset.
REQ-029 i_start while not IDLE SHALL be ignored.
REQ-030 i_stop in ACC or DONE SHALL go to IDLE next cycle, dropping any partial or pending result; i_stop in IDLE has no effect.
REQ-031 i_stop and transfer in the same DONE cycle: transfer completes, next state IDLE regardless of mode.
REQ-032 i_start and i_stop together in IDLE: i_stop wins, remain IDLE.

Reset
REQ-033 On i_rst_n low at a clock edge: state IDLE, o_valid=0, o_busy=0, o_drop=0, o_avg=0, o_min=0, o_max=0, o_chan=0, accumulator and counter 0.
REQ-034 Reset mid-measurement SHALL abandon all state with no result emitted.

Structure
REQ-035 Package x_dl_pkg SHALL hold the FSM state enum and a width helper function for CW.
REQ-036 Thermometer-to-count conversion SHALL be a combinational sub-module x_dl_therm2cnt (parameter p_width).

Verification (p_width=32, p_chans=4, p_log_avg=2)
REQ-037 Start ch1 single-shot, ch1 samples counts 10,12,14,16 -> o_valid one cycle after 4th sample, o_avg=13, o_min=10, o_max=16, o_chan=1; after accept, IDLE, o_busy=0.
REQ-038 Sample 0x0000_FF7F on ch0 -> count 7; 0xFFFF_FFFF -> 32; 0x0000_0000 -> 0.
REQ-039 Continuous mode, hold i_accept=0 three cycles in DONE with i_dl_valid=1 -> o_valid and data stable, o_drop=1; accept -> next window starts fresh.
REQ-040 i_stop after 2 samples -> IDLE next cycle, o_valid never asserted; new start yields correct result from clean state.
REQ-041 i_rst_n low during ACC and during DONE -> all outputs at reset values next cycle.
REQ-042 Continuous mode with i_stop and i_accept together in DONE -> one transfer, then IDLE.
